conv_host_if: RTL and testbench

CONV_HOST_IF -- requirements
Module: conv_host_if

---
 rtl/conv_host_if.sv | 237 +++++++++++++++++++++++
 tb/tb_conv_host_if.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_host_if
//  Description : Host-side wrapper for a CONV accelerator. Holds the image
//                buffer and the two layer memories (L0 4096x20, L1 1024x20),
//                and sequences one run per host start through
//                IDLE -> READY -> RUN -> DONE. READY and RUN are guarded by
//                cycle-count timeouts.
//
//  Ports
//    clk, reset                     clock, synchronous active-high reset
//    start                          host command, begins one run
//    ld_en / ld_addr / ld_data      image buffer write (IDLE/DONE only)
//    ready -> / busy <-             handshake with CONV
//    iaddr / idata                  image fetch, 1-cycle latency, 0 outside RUN
//    cwr / caddr_wr / cdata_wr      layer-memory write (RUN only)
//    crd / caddr_rd / cdata_rd      layer-memory read, 1-cycle latency
//    csel                           bank select: 001 = L0, 011 = L1
//    rb_sel / rb_addr / rb_data     host readback, independent read port
//    done / timeout / l0_written / l1_written   status
//
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_host_if #(
    parameter int READY_TIMEOUT = 16,
    parameter int RUN_TIMEOUT   = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_en,
    input  logic [11:0] ld_addr,
    input  logic [19:0] ld_data,
    output logic        ready,
    input  logic        busy,
    input  logic [11:0] iaddr,
    output logic [19:0] idata,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [19:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [19:0] cdata_rd,
    input  logic [2:0]  csel,
    input  logic        rb_sel,
    input  logic [11:0] rb_addr,
    output logic [19:0] rb_data,
    output logic        done,
    output logic        timeout,
    output logic        l0_written,
    output logic        l1_written
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_ready = 2'd1;
    localparam logic [1:0]  c_st_run   = 2'd2;
    localparam logic [1:0]  c_st_done  = 2'd3;

    localparam logic [2:0]  c_csel_l0  = 3'b001;
    localparam logic [2:0]  c_csel_l1  = 3'b011;

    // The counter starts at 0 on the first cycle of a state, so the timeout
    // fires at the edge that closes the N-th cycle spent in that state.
    localparam logic [23:0] c_ready_last = 24'(READY_TIMEOUT - 1);
    localparam logic [23:0] c_run_last   = 24'(RUN_TIMEOUT - 1);
    localparam logic [23:0] c_cnt_max    = 24'hFF_FFFF;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [19:0] r_img [0:4095];
    logic [19:0] r_l0  [0:4095];
    logic [19:0] r_l1  [0:1023];

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [23:0] r_cnt;
    logic        r_done;
    logic        r_timeout;
    logic        r_l0_written;
    logic        r_l1_written;
    logic [19:0] r_idata;
    logic [19:0] r_cdata_rd;
    logic [19:0] r_rb_data;

    logic        w_accept_start;
    logic        w_set_done;
    logic        w_set_timeout;
    logic        w_in_run;
    logic        w_host_side;
    logic        w_ld_we;
    logic        w_l0_we;
    logic        w_l1_we;
    logic        w_l0_re;
    logic        w_l1_re;

    // ------------------------------------------------------------------------
    // Access qualification. Writes are also gated by reset so that a reset
    // edge landing mid-run cannot slip one last write into a bank.
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_run    = (r_state == c_st_run);
        w_host_side = (r_state == c_st_idle) || (r_state == c_st_done);
        w_ld_we     = ld_en && w_host_side && !reset;
        w_l0_we     = cwr && w_in_run && (csel == c_csel_l0) && !reset;
        w_l1_we     = cwr && w_in_run && (csel == c_csel_l1) && !reset;
        w_l0_re     = crd && w_in_run && (csel == c_csel_l0);
        w_l1_re     = crd && w_in_run && (csel == c_csel_l1);
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and event decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_set_done     = 1'b0;
        w_set_timeout  = 1'b0;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt    = c_st_ready;
                    w_accept_start = 1'b1;
                end
            end
            c_st_ready: begin
                // busy wins over a timeout landing on the same cycle
                if (busy) begin
                    w_state_nxt = c_st_run;
                end else if (r_cnt >= c_ready_last) begin
                    w_state_nxt   = c_st_idle;
                    w_set_timeout = 1'b1;
                end
            end
            c_st_run: begin
                if (!busy) begin
                    w_state_nxt = c_st_done;
                    w_set_done  = 1'b1;
                end else if (r_cnt >= c_run_last) begin
                    w_state_nxt   = c_st_idle;
                    w_set_timeout = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state, cycle counter and sticky status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_l0_written <= 1'b0;
            r_l1_written <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 24'd1;
            end

            // A start is only accepted in IDLE/DONE, where none of the set
            // events below can occur, so clear and set never collide.
            if (w_accept_start) begin
                r_done       <= 1'b0;
                r_timeout    <= 1'b0;
                r_l0_written <= 1'b0;
                r_l1_written <= 1'b0;
            end else begin
                if (w_set_done)    r_done       <= 1'b1;
                if (w_set_timeout) r_timeout    <= 1'b1;
                if (w_l0_we)       r_l0_written <= 1'b1;
                if (w_l1_we)       r_l1_written <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory writes. Contents survive reset and start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ld_we) r_img[ld_addr]        <= ld_data;
        if (w_l0_we) r_l0[caddr_wr]        <= cdata_wr;
        if (w_l1_we) r_l1[caddr_wr[9:0]]   <= cdata_wr;
    end

    // ------------------------------------------------------------------------
    // Registered read ports. Reads sample the array before this edge's write
    // lands, giving old-data behaviour on a same-address collision.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idata    <= '0;
            r_cdata_rd <= '0;
            r_rb_data  <= '0;
        end else begin
            r_idata <= r_img[iaddr];

            if (w_l0_re) begin
                r_cdata_rd <= r_l0[caddr_rd];
            end else if (w_l1_re) begin
                r_cdata_rd <= r_l1[caddr_rd[9:0]];
            end

            r_rb_data <= rb_sel ? r_l1[rb_addr[9:0]] : r_l0[rb_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. idata is forced to zero outside RUN so CONV never sees image
    // data while the host side owns the buffer.
    // ------------------------------------------------------------------------
    assign ready      = (r_state == c_st_ready);
    assign idata      = w_in_run ? r_idata : 20'd0;
    assign cdata_rd   = r_cdata_rd;
    assign rb_data    = r_rb_data;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign l0_written = r_l0_written;
    assign l1_written = r_l1_written;

endmodule
`default_nettype wire

// File: tb/tb_conv_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_host_if
//  Description : Self-checking bench for conv_host_if. Directed scenarios plus
//                randomized runs checked against a memory-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_host_if;

    localparam int READY_TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [19:0] ld_data;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        rb_sel;
    logic [11:0] rb_addr;
    logic [19:0] rb_data;
    logic        done;
    logic        timeout;
    logic        l0_written;
    logic        l1_written;

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays with "known" flags
    logic [19:0] m_img [0:4095];
    bit          m_imgk[0:4095];
    logic [19:0] m_l0  [0:4095];
    bit          m_l0k [0:4095];
    logic [19:0] m_l1  [0:1023];
    bit          m_l1k [0:1023];
    logic [11:0] img_q [$];

    always #5 clk = ~clk;

    conv_host_if dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
        .done(done), .timeout(timeout),
        .l0_written(l0_written), .l1_written(l1_written)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; ld_en = 0; ld_addr = 0; ld_data = 0; busy = 0; iaddr = 0;
        cwr = 0; caddr_wr = 0; cdata_wr = 0; crd = 0; caddr_rd = 0;
        csel = 0; rb_sel = 0; rb_addr = 0;
    endtask

    task automatic load_img(input logic [11:0] a, input logic [19:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
        m_img[a] = d; m_imgk[a] = 1;
        img_q.push_back(a);
    endtask

    // start from IDLE/DONE, spend 'delay' cycles in READY, then raise busy
    task automatic go_run(input int delay);
        start = 1;
        tick();
        start = 0;
        repeat (delay - 1) tick();
        busy = 1;
        tick();
    endtask

    function automatic logic [11:0] rnd_addr();
        logic [1:0] hi;
        logic [2:0] lo;
        hi = 2'($urandom_range(0, 3));
        lo = 3'($urandom_range(0, 7));
        return {hi, 7'd0, lo};
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        total++; if (ready !== 1'b0)      begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (timeout !== 1'b0)    begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        total++; if (l0_written !== 1'b0) begin bad++; $display("FAIL rst_l0w: got %b want 0", l0_written); end
        total++; if (l1_written !== 1'b0) begin bad++; $display("FAIL rst_l1w: got %b want 0", l1_written); end
        total++; if (idata !== 20'd0)     begin bad++; $display("FAIL rst_idata: got %h want 0", idata); end
        total++; if (cdata_rd !== 20'd0)  begin bad++; $display("FAIL rst_cdata: got %h want 0", cdata_rd); end
        total++; if (rb_data !== 20'd0)   begin bad++; $display("FAIL rst_rb: got %h want 0", rb_data); end
        reset = 0;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_image_fetch();
        load_img(12'd5, 20'h0A0B0);
        load_img(12'd6, 20'($urandom));
        start = 1;
        tick();
        start = 0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL fetch_ready_up: got %b want 1", ready); end
        tick(); tick();
        busy = 1;
        tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fetch_ready_down: got %b want 0", ready); end
        iaddr = 12'd5;
        tick();
        total++; if (idata !== m_img[5]) begin bad++; $display("FAIL fetch_idata5: got %h want %h", idata, m_img[5]); end
        iaddr = 12'd6;
        tick();
        total++; if (idata !== m_img[6]) begin bad++; $display("FAIL fetch_idata6: got %h want %h", idata, m_img[6]); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_layer_write();
        cwr = 1; csel = 3'b001; caddr_wr = 12'hFFF; cdata_wr = 20'h12345;
        tick();
        m_l0[12'hFFF] = 20'h12345; m_l0k[12'hFFF] = 1;
        csel = 3'b011; caddr_wr = 12'h7FF; cdata_wr = 20'h00ABC;
        tick();
        m_l1[10'h3FF] = 20'h00ABC; m_l1k[10'h3FF] = 1;
        cwr = 0; csel = 0; busy = 0;
        tick();
        total++; if (done !== 1'b1)       begin bad++; $display("FAIL lw_done: got %b want 1", done); end
        total++; if (l0_written !== 1'b1) begin bad++; $display("FAIL lw_l0w: got %b want 1", l0_written); end
        total++; if (l1_written !== 1'b1) begin bad++; $display("FAIL lw_l1w: got %b want 1", l1_written); end
        total++; if (idata !== 20'd0)     begin bad++; $display("FAIL lw_idata_idle: got %h want 0", idata); end
        rb_sel = 0; rb_addr = 12'hFFF;
        tick();
        total++; if (rb_data !== 20'h12345) begin bad++; $display("FAIL lw_rb_l0: got %h want 12345", rb_data); end
        rb_sel = 1; rb_addr = 12'h7FF;
        tick();
        total++; if (rb_data !== 20'h00ABC) begin bad++; $display("FAIL lw_rb_l1: got %h want 00abc", rb_data); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_invalid_csel();
        go_run(1);
        cwr = 1; csel = 3'b010; caddr_wr = 12'hFFF; cdata_wr = 20'h55555;
        tick();
        csel = 3'b000; caddr_wr = 12'h7FF;
        tick();
        cwr = 0; csel = 0; busy = 0;
        tick();
        total++; if (done !== 1'b1)       begin bad++; $display("FAIL inv_done: got %b want 1", done); end
        total++; if (l0_written !== 1'b0) begin bad++; $display("FAIL inv_l0w: got %b want 0", l0_written); end
        total++; if (l1_written !== 1'b0) begin bad++; $display("FAIL inv_l1w: got %b want 0", l1_written); end
        rb_sel = 0; rb_addr = 12'hFFF;
        tick();
        total++; if (rb_data !== m_l0[12'hFFF]) begin bad++; $display("FAIL inv_rb_l0: got %h want %h", rb_data, m_l0[12'hFFF]); end
        rb_sel = 1; rb_addr = 12'h7FF;
        tick();
        total++; if (rb_data !== m_l1[10'h3FF]) begin bad++; $display("FAIL inv_rb_l1: got %h want %h", rb_data, m_l1[10'h3FF]); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_ready_timeout();
        int n;
        busy = 0;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (ready === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        total++; if (n != READY_TO)    begin bad++; $display("FAIL to_ready_cycles: got %0d want %0d", n, READY_TO); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_timeout: got %b want 1", timeout); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL to_done: got %b want 0", done); end
        // back in IDLE: a new start is accepted and clears timeout
        start = 1;
        tick();
        start = 0;
        total++; if (ready !== 1'b1 || timeout !== 1'b0) begin
            bad++; $display("FAIL to_restart: got ready=%b timeout=%b want 1/0", ready, timeout);
        end
        busy = 1;
        tick();
        busy = 0;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_rdw();
        go_run(2);
        cwr = 1; csel = 3'b001; caddr_wr = 12'd7; cdata_wr = 20'h00001;
        tick();
        cdata_wr = 20'h00002; crd = 1; caddr_rd = 12'd7;
        tick();
        total++; if (cdata_rd !== 20'h00001) begin bad++; $display("FAIL rdw_old: got %h want 00001", cdata_rd); end
        cwr = 0;
        tick();
        total++; if (cdata_rd !== 20'h00002) begin bad++; $display("FAIL rdw_new: got %h want 00002", cdata_rd); end
        crd = 0; caddr_rd = 12'd5;
        tick();
        total++; if (cdata_rd !== 20'h00002) begin bad++; $display("FAIL rdw_hold: got %h want 00002", cdata_rd); end
        m_l0[7] = 20'h00002; m_l0k[7] = 1;
        csel = 0; busy = 0;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_in_run();
        go_run(1);
        cwr = 1; csel = 3'b001; caddr_wr = 12'd100; cdata_wr = 20'hAAAAA;
        tick();
        m_l0[100] = 20'hAAAAA; m_l0k[100] = 1;
        cwr = 0;
        reset = 1;
        tick();
        reset = 0;
        total++; if (ready !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rir_status: got ready=%b done=%b want 0/0", ready, done);
        end
        cwr = 1; caddr_wr = 12'd100; cdata_wr = 20'hBBBBB;
        tick();
        cwr = 0;
        tick();
        total++; if (ready !== 1'b0 || l0_written !== 1'b0) begin
            bad++; $display("FAIL rir_after: got ready=%b l0w=%b want 0/0", ready, l0_written);
        end
        rb_sel = 0; rb_addr = 12'd100;
        tick();
        total++; if (rb_data !== m_l0[100]) begin bad++; $display("FAIL rir_mem: got %h want %h", rb_data, m_l0[100]); end
        clear_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        logic [2:0]  csel_tab [0:4];
        logic [19:0] exp_idata;
        logic [19:0] exp_cd;
        bit          cd_known;
        bit          exp_l0w;
        bit          exp_l1w;
        logic [11:0] ra;
        csel_tab[0] = 3'b001; csel_tab[1] = 3'b011; csel_tab[2] = 3'b010;
        csel_tab[3] = 3'b000; csel_tab[4] = 3'b111;
        cd_known = 0;
        exp_cd   = '0;
        for (int run = 0; run < 6; run++) begin
            for (int k = 0; k < 4; k++) load_img(12'($urandom), 20'($urandom));
            start = 1;
            tick();
            start = 0;
            // writes attempted in READY must be ignored
            for (int d = 0; d < int'($urandom_range(1, 6)); d++) begin
                cwr = 1; csel = 3'b001; caddr_wr = rnd_addr(); cdata_wr = 20'($urandom);
                tick();
            end
            cwr = 0;
            busy = 1;
            tick();
            exp_l0w = 0; exp_l1w = 0;
            for (int c = 0; c < 40; c++) begin
                iaddr    = img_q[$urandom_range(0, img_q.size() - 1)];
                csel     = csel_tab[$urandom_range(0, 4)];
                cwr      = 1'($urandom);
                caddr_wr = rnd_addr();
                cdata_wr = 20'($urandom);
                crd      = 1'($urandom);
                caddr_rd = rnd_addr();
                ld_en    = 1'($urandom);
                ld_addr  = iaddr;
                ld_data  = 20'($urandom);
                start    = ($urandom_range(0, 7) == 0);
                exp_idata = m_img[iaddr];
                if (crd && csel == 3'b001) begin
                    cd_known = m_l0k[caddr_rd];
                    exp_cd   = m_l0[caddr_rd];
                end else if (crd && csel == 3'b011) begin
                    cd_known = m_l1k[caddr_rd[9:0]];
                    exp_cd   = m_l1[caddr_rd[9:0]];
                end
                if (cwr && csel == 3'b001) begin
                    m_l0[caddr_wr] = cdata_wr; m_l0k[caddr_wr] = 1; exp_l0w = 1;
                end else if (cwr && csel == 3'b011) begin
                    m_l1[caddr_wr[9:0]] = cdata_wr; m_l1k[caddr_wr[9:0]] = 1; exp_l1w = 1;
                end
                tick();
                total++; if (idata !== exp_idata) begin bad++; $display("FAIL rnd_idata: got %h want %h", idata, exp_idata); end
                if (cd_known) begin
                    total++; if (cdata_rd !== exp_cd) begin bad++; $display("FAIL rnd_cdata: got %h want %h", cdata_rd, exp_cd); end
                end
            end
            cwr = 0; crd = 0; ld_en = 0; start = 0; csel = 0; busy = 0;
            tick();
            total++; if (done !== 1'b1 || timeout !== 1'b0) begin
                bad++; $display("FAIL rnd_done: got done=%b timeout=%b want 1/0", done, timeout);
            end
            total++; if (l0_written !== exp_l0w || l1_written !== exp_l1w) begin
                bad++; $display("FAIL rnd_flags: got %b%b want %b%b", l0_written, l1_written, exp_l0w, exp_l1w);
            end
            for (int r = 0; r < 8; r++) begin
                ra      = rnd_addr();
                rb_sel  = 1'($urandom);
                rb_addr = ra;
                tick();
                if (rb_sel == 1'b0 && m_l0k[ra]) begin
                    total++; if (rb_data !== m_l0[ra]) begin bad++; $display("FAIL rnd_rb_l0: got %h want %h", rb_data, m_l0[ra]); end
                end else if (rb_sel == 1'b1 && m_l1k[ra[9:0]]) begin
                    total++; if (rb_data !== m_l1[ra[9:0]]) begin bad++; $display("FAIL rnd_rb_l1: got %h want %h", rb_data, m_l1[ra[9:0]]); end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin m_imgk[i] = 0; m_l0k[i] = 0; end
        for (int i = 0; i < 1024; i++) m_l1k[i] = 0;
        test_reset();
        test_image_fetch();
        test_layer_write();
        test_invalid_csel();
        test_ready_timeout();
        test_rdw();
        test_reset_in_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
